secuenciador_arbitrado: RTL
===========================

# secuenciador_arbitrado

Sequencer and arbiter for the shared term-evaluation datapath (constant ROM mux, function mux, accumulator). Several requesters each ask for a full evaluation. The block grants the datapath to one requester at a time in round-robin order. It then steps the constant, function and accumulator selects through every term, captures the accumulated result, and returns a one-cycle completion pulse to the granted requester.

## Interface
- N_REQ, 2, number of requesters (2..8)
- N_TERMS, 5, terms per evaluation (1..7; sel_const width fixed at 3)
- ANCHO, 16, width of accumulator result
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  level request per requester; held until its listo pulse
- acum_in  in  ANCHO  accumulator output from datapath
- grant  out  N_REQ  one-hot owner of the datapath; 0 when idle
- sel_const  out  3  constant select (term index)
- sel_fun  out  2  function select
- sel_acum  out  1  1 = accumulate the current term
- clr_acum  out  1  1 = clear accumulator
- listo  out  N_REQ  one-cycle completion pulse to the grantee
- resultado  out  ANCHO  captured result; valid from listo until the next capture
- ocupado  out  1  1 whenever state is not IDLE

## Operation
- Reset (async, any time including mid-evaluation):
  - state IDLE, RR pointer 0.
  - All outputs 0: grant, sel_*, clr_acum, listo, resultado, ocupado.
- States, with all outputs decoded from registered state and counters:
  - IDLE: no outputs asserted. If req≠0, arbitrate, register grant and go to GRANT. Otherwise stay.
  - GRANT: clr_acum=1, sel_acum=0, sel_const=0, sel_fun=0. Load k=1, go to TERM.
  - TERM: sel_const=k, sel_fun=k mod 3 (1,2,0,1,2 for k=1..5), sel_acum=1. If k=N_TERMS go to WAIT, else k←k+1.
  - WAIT: sel_acum=0, sel_const=0, sel_fun=0. This cycle absorbs the accumulator register latency. On exit, resultado←acum_in, go to DONE.
  - DONE: listo[g]=1 for grantee g. Next state is IDLE; grant clears on that transition.
- grant stays constant from GRANT through DONE.
- Arbitration: round robin.
  - Search starts at index (last grantee+1) mod N_REQ; after reset it starts at index 0.
  - The pointer updates only when a grant is issued.
- A requester dropping req mid-evaluation does not abort. The sequence completes and listo still pulses.
- A requester holding req after listo is treated as a new request in the following IDLE cycle, after other pending requesters in RR order.
- Unused state encodings go to IDLE with outputs 0.
- k is 3 bits and never exceeds N_TERMS.

## Timing
- req sampled at edge E0 in IDLE:
  - GRANT during E0→E1
  - TERM k=1..N_TERMS during E1→E(N_TERMS+1)
  - WAIT one cycle
  - DONE (listo high) starting at E(N_TERMS+2); for N_TERMS=5 that is 7 cycles after sampling.
- resultado updates on the edge entering DONE and holds until the next such edge.
- Back-to-back: DONE→IDLE→GRANT. There is one idle cycle between evaluations, so one evaluation takes N_TERMS+4 cycles (9 for the default).
- No combinational path from req or acum_in to any output.

## Structure
- Shared package secuenciador_pkg holds:
  - state enum (IDLE, GRANT, TERM, WAIT, DONE)
  - default N_TERMS
  - function fun_de_termino(k) returning k mod 3 as 2 bits
- Sub-module arbitro_rr: combinational N_REQ round-robin arbiter. Inputs are req and the pointer; outputs are one-hot grant and grantee index. The pointer register lives in the parent.

## Test plan
- Single request on req=2'b01, acum_in driven 16'h1234 during WAIT:
  - sel_const sequence 0,1,2,3,4,5,0; sel_fun 0,1,2,0,1,2,0.
  - clr_acum high only in GRANT.
  - listo=2'b01 exactly 7 cycles after sampling; resultado=16'h1234.
- Both requests held continuously after reset:
  - grants alternate 01,10,01.
  - listo pulses 9 cycles apart, each matching the current grant.
- req[0] dropped during TERM k=3: sequence completes; listo[0] still pulses; no re-grant to 0 afterwards.
- reset pulsed during TERM k=4:
  - all outputs 0 asynchronously.
  - after release with req=2'b10, grant=2'b10; pointer restarted at 0, so requester 1 wins only because requester 0 is absent.
- N_TERMS=1 build: sel_const takes a single value 1; listo 3 cycles after sampling.
- Idle stability: req=0 for 20 cycles; ocupado, grant and listo stay 0; resultado holds its last value.

Source files
------------

// File: rtl/secuenciador_pkg.sv
// secuenciador_pkg: shared state encoding, default term count and term-to-function mapping
package secuenciador_pkg;
    typedef enum logic [2:0] {IDLE, GRANT, TERM, WAIT, DONE} estado_t;
    localparam int N_TERMS_DEF = 5;
    function automatic logic [1:0] fun_de_termino(input logic [2:0] k);
        return 2'(k % 3'd3);
    endfunction
endpackage

// File: rtl/secuenciador_arbitrado_arbitro_rr.sv
// arbitro_rr: combinational round-robin arbiter, search starts at i_ptr
// Ports: i_req requests, i_ptr first index searched, o_grant one-hot winner, o_idx winner index
module arbitro_rr
    import secuenciador_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx
);
    logic [IW-1:0] w_j;
    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        o_grant = '0;
        o_idx = '0;
        w_j = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_j = IW'((int'(i_ptr) + i) % N_REQ);
            if (i_req[w_j]) begin
                o_grant = '0;
                o_grant[w_j] = 1'b1;
                o_idx = w_j;
            end
        end
    end
endmodule

// File: rtl/secuenciador_arbitrado.sv
// secuenciador_arbitrado: round-robin owner of the term datapath, steps selects and captures the result
// Ports: i_clk, i_reset (async high), i_req level requests, i_acum_in accumulator value;
//        o_grant owner, o_sel_const/o_sel_fun/o_sel_acum/o_clr_acum datapath controls,
//        o_listo completion pulse, o_resultado captured result, o_ocupado busy
module secuenciador_arbitrado
    import secuenciador_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int ANCHO = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic [ANCHO-1:0] i_acum_in,
    output logic [N_REQ-1:0] o_grant,
    output logic [2:0]       o_sel_const,
    output logic [1:0]       o_sel_fun,
    output logic             o_sel_acum,
    output logic             o_clr_acum,
    output logic [N_REQ-1:0] o_listo,
    output logic [ANCHO-1:0] o_resultado,
    output logic             o_ocupado
);
    localparam int IW = $clog2(N_REQ);
    estado_t r_estado;
    logic [2:0] r_k;
    logic [IW-1:0] r_ptr;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0] w_idx;
    arbitro_rr #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .i_req(i_req),
        .i_ptr(r_ptr),
        .o_grant(w_grant),
        .o_idx(w_idx)
    );
    // Outputs are loaded together with the state they belong to, so they are all registered
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_estado <= IDLE;
            r_k <= '0;
            r_ptr <= '0;
            o_grant <= '0;
            o_sel_const <= '0;
            o_sel_fun <= '0;
            o_sel_acum <= 1'b0;
            o_clr_acum <= 1'b0;
            o_listo <= '0;
            o_resultado <= '0;
            o_ocupado <= 1'b0;
        end else begin
            o_listo <= '0;
            o_clr_acum <= 1'b0;
            o_sel_acum <= 1'b0;
            o_sel_const <= '0;
            o_sel_fun <= '0;
            case (r_estado)
                IDLE: if (|i_req) begin
                    r_estado <= GRANT;
                    o_grant <= w_grant;
                    r_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
                    o_clr_acum <= 1'b1;
                    o_ocupado <= 1'b1;
                end
                GRANT: begin
                    r_estado <= TERM;
                    r_k <= 3'd1;
                    o_sel_const <= 3'd1;
                    o_sel_fun <= fun_de_termino(3'd1);
                    o_sel_acum <= 1'b1;
                end
                TERM: if (r_k == 3'(N_TERMS)) begin
                    r_estado <= WAIT;
                end else begin
                    r_k <= r_k + 3'd1;
                    o_sel_const <= r_k + 3'd1;
                    o_sel_fun <= fun_de_termino(r_k + 3'd1);
                    o_sel_acum <= 1'b1;
                end
                // Accumulator register has settled on the last term by the end of WAIT
                WAIT: begin
                    r_estado <= DONE;
                    o_resultado <= i_acum_in;
                    o_listo <= o_grant;
                end
                DONE: begin
                    r_estado <= IDLE;
                    r_k <= '0;
                    o_grant <= '0;
                    o_ocupado <= 1'b0;
                end
                default: begin
                    r_estado <= IDLE;
                    r_k <= '0;
                    o_grant <= '0;
                    o_ocupado <= 1'b0;
                end
            endcase
        end
    end
endmodule
